// File: rtl/alu_fu_pipe.sv
// alu_fu_pipe: pipelined integer ALU functional unit for the out-of-order backend.
//
// An issued op is computed combinationally from its operands and captured into
// slot 0. It then moves through STAGES register slots to the CDB. The last slot
// drives the out_* ports straight from its registers. A flush kills every
// in-flight op and the op offered in the same cycle.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
// ready are both 1. A producer holds valid and its payload until the transfer.
// in_valid may drop without a transfer. While out_valid=1 and out_ready=0, the
// out_* payload is held stable. in_ready depends combinationally on out_ready
// through the slot chain. A full pipeline therefore accepts an op in the same
// cycle the CDB drains one.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   flush        kill all in-flight ops and the current input
//   in_valid     issue request from the reservation station
//   in_ready     unit can accept this cycle (0 while in reset)
//   in_op        op code: 0 add, 1 sll, 2 sra, 3 sub, 4 xor, 5 srl, 6 or,
//                7 and, 8 slt, 9 sltu, 10..15 illegal
//   in_a, in_b   operands (shift amount is in_b[$clog2(XLEN)-1:0])
//   in_tag       ROB tag carried with the op
//   out_valid    result available to the CDB arbiter
//   out_ready    CDB accepts the result
//   out_data     result
//   out_tag      ROB tag of the result
//   out_illegal  op code was unsupported (out_data is 0)
module alu_fu_pipe #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int SW   = $clog2(XLEN);
  localparam int LAST = STAGES - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SRA  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  // ---------------- combinational ALU ----------------
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;

  assign shamt = in_b[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (in_op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SRA:  alu_res = $unsigned($signed(in_a) >>> shamt);
      OP_SUB:  alu_res = in_a - in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_OR:   alu_res = in_a | in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default: alu_ill = 1'b1;
    endcase
  end

  // ---------------- slot storage ----------------
  logic [STAGES-1:0] slot_v;
  logic [XLEN-1:0]   slot_d [STAGES];
  logic [TAG_W-1:0]  slot_t [STAGES];
  logic [STAGES-1:0] slot_i;
  logic [STAGES-1:0] adv;
  logic              alive;
  logic              take;

  // Slot k advances when it holds an op and either some later slot is empty,
  // which opens a gap that ripples forward, or the whole tail is full and the
  // CDB drains the last slot. This is the closed form of the per-slot chain
  // "next slot empty or next slot advancing".
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    if (k == LAST) begin : g_last
      assign adv[k] = slot_v[k] & out_ready;
    end else begin : g_mid
      assign adv[k] = slot_v[k] & (~(&slot_v[LAST:k+1]) | out_ready);
    end
  end

  // alive keeps in_ready low during reset and until the first edge after release.
  assign in_ready = alive & (~slot_v[0] | adv[0]);
  assign take     = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_v <= '0;
      slot_i <= '0;
      for (int k = 0; k < STAGES; k++) begin
        slot_d[k] <= '0;
        slot_t[k] <= '0;
      end
    end else begin
      // Slot 0: capture a newly issued op.
      if (flush)       slot_v[0] <= 1'b0;
      else if (take)   slot_v[0] <= 1'b1;
      else if (adv[0]) slot_v[0] <= 1'b0;
      if (take) begin
        slot_d[0] <= alu_res;
        slot_t[0] <= in_tag;
        slot_i[0] <= alu_ill;
      end
      // Slots 1..LAST: forward only. Payload may load during a flush; the
      // valid bit is what kills the op, and the payload stays a defined value.
      for (int k = 1; k < STAGES; k++) begin
        if (flush)         slot_v[k] <= 1'b0;
        else if (adv[k-1]) slot_v[k] <= 1'b1;
        else if (adv[k])   slot_v[k] <= 1'b0;
        if (adv[k-1]) begin
          slot_d[k] <= slot_d[k-1];
          slot_t[k] <= slot_t[k-1];
          slot_i[k] <= slot_i[k-1];
        end
      end
    end
  end

  assign out_valid   = slot_v[LAST];
  assign out_data    = slot_d[LAST];
  assign out_tag     = slot_t[LAST];
  assign out_illegal = slot_i[LAST];

endmodule

// File: tb/tb_alu_fu_pipe.sv
// Self-checking bench for alu_fu_pipe. Three instances with STAGES = 1, 2 and 4
// share the operand and flush inputs. in_valid and out_ready are steered to the
// instance under test, and the other two sit idle and drained. Each feature
// task drives its stimulus and checks inline. Expected results come from a
// behavioural model of the op table plus an expected queue.
module tb_alu_fu_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int W     = XLEN + TAG_W + 1;

  // ---------------- clock / reset / stimulus signals ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [3:0]       in_op = '0;
  logic [XLEN-1:0]  in_a = '0;
  logic [XLEN-1:0]  in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;

  int sel = 0;
  int stg = 1;
  int checks = 0;
  int errors = 0;

  logic [2:0]       ivv, orv, ir_v, ov_v, oil_v;
  logic [XLEN-1:0]  od_v [3];
  logic [TAG_W-1:0] ot_v [3];

  logic             dut_in_ready, dut_out_valid, dut_out_illegal;
  logic [XLEN-1:0]  dut_out_data;
  logic [TAG_W-1:0] dut_out_tag;
  logic [W-1:0]     dut_word;

  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    ivv             = in_valid ? (3'b001 << sel) : 3'b000;
    orv             = out_ready ? 3'b111 : ~(3'b001 << sel);
    dut_in_ready    = ir_v[sel];
    dut_out_valid   = ov_v[sel];
    dut_out_illegal = oil_v[sel];
    dut_out_data    = od_v[sel];
    dut_out_tag     = ot_v[sel];
    dut_word        = {oil_v[sel], ot_v[sel], od_v[sel]};
  end

  alu_fu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(ivv[0]), .in_ready(ir_v[0]),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(ov_v[0]), .out_ready(orv[0]), .out_data(od_v[0]), .out_tag(ot_v[0]),
    .out_illegal(oil_v[0]));

  alu_fu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(ivv[1]), .in_ready(ir_v[1]),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(ov_v[1]), .out_ready(orv[1]), .out_data(od_v[1]), .out_tag(ot_v[1]),
    .out_illegal(oil_v[1]));

  alu_fu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(ivv[2]), .in_ready(ir_v[2]),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(ov_v[2]), .out_ready(orv[2]), .out_data(od_v[2]), .out_tag(ot_v[2]),
    .out_illegal(oil_v[2]));

  // ---------------- reference model ----------------
  // Result word {illegal, tag, data} from the op table, bit by bit for sra.
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    logic [XLEN-1:0] r;
    logic            ill;
    int              sh;
    longint          sa, sb, ua, ub;
    r   = '0;
    ill = 1'b0;
    sh  = int'(b % XLEN);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    case (op)
      4'd0: r = a + b;
      4'd1: r = a << sh;
      4'd2: for (int i = 0; i < XLEN; i++) r[i] = (i + sh < XLEN) ? a[i + sh] : a[XLEN-1];
      4'd3: r = a - b;
      4'd4: r = a ^ b;
      4'd5: r = a >> sh;
      4'd6: r = a | b;
      4'd7: r = a & b;
      4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r = (ua < ub) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
    return {ill, tag, r};
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- timing helpers ----------------
  // Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ---------------- feature tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) step();
    sample();
    checks++; if (dut_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid[S=%0d]: got %b want 0", stg, dut_out_valid); end
    checks++; if (dut_out_data !== 32'h0) begin errors++; $display("FAIL reset_data[S=%0d]: got %h want 0", stg, dut_out_data); end
    checks++; if (dut_out_tag !== 5'h0) begin errors++; $display("FAIL reset_tag[S=%0d]: got %h want 0", stg, dut_out_tag); end
    checks++; if (dut_out_illegal !== 1'b0) begin errors++; $display("FAIL reset_ill[S=%0d]: got %b want 0", stg, dut_out_illegal); end
    checks++; if (dut_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready[S=%0d]: got %b want 0", stg, dut_in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (dut_in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early[S=%0d]: got %b want 0", stg, dut_in_ready); end
    step();
    sample();
    checks++; if (dut_in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready[S=%0d]: got %b want 1", stg, dut_in_ready); end
    step();
  endtask

  // Issue one op into an empty pipeline with out_ready=1 and check exact latency.
  task automatic issue_one(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] ed, input logic eil,
                           input string name);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    sample();
    checks++; if (dut_in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept[S=%0d]: got %b want 1", name, stg, dut_in_ready); end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < stg - 1; i++) begin
      sample();
      checks++; if (dut_out_valid !== 1'b0) begin errors++; $display("FAIL %s_early[S=%0d]: got valid %b at cycle %0d want 0", name, stg, dut_out_valid, i + 1); end
      step();
    end
    sample();
    checks++; if (dut_out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency[S=%0d]: got valid %b want 1", name, stg, dut_out_valid); end
    checks++; if (dut_out_data !== ed) begin errors++; $display("FAIL %s_data[S=%0d]: got %h want %h", name, stg, dut_out_data, ed); end
    checks++; if (dut_out_tag !== tag) begin errors++; $display("FAIL %s_tag[S=%0d]: got %h want %h", name, stg, dut_out_tag, tag); end
    checks++; if (dut_out_illegal !== eil) begin errors++; $display("FAIL %s_ill[S=%0d]: got %b want %b", name, stg, dut_out_illegal, eil); end
    step();
  endtask

  task automatic test_basic();
    issue_one(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd3, 32'h0, 1'b0, "add_wrap");
  endtask

  task automatic test_back_to_back();
    logic [3:0]       ops  [4] = '{4'd2, 4'd9, 4'd8, 4'd3};
    logic [XLEN-1:0]  as   [4] = '{32'h8000_0000, 32'h1, 32'h1, 32'h0};
    logic [XLEN-1:0]  bs   [4] = '{32'h24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
    logic [XLEN-1:0]  eds  [4] = '{32'hF800_0000, 32'h1, 32'h0, 32'hFFFF_FFFF};
    logic [TAG_W-1:0] tags [4] = '{5'd10, 5'd11, 5'd12, 5'd13};
    int oi;
    logic exp_v;
    out_ready = 1'b1;
    for (int c = 0; c < 4 + stg + 1; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_op = ops[c]; in_a = as[c]; in_b = bs[c]; in_tag = tags[c];
      end else begin
        in_valid = 1'b0;
      end
      sample();
      if (c < 4) begin
        checks++; if (dut_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[S=%0d]: got %b want 1 at cycle %0d", stg, dut_in_ready, c); end
      end
      oi = c - stg;
      exp_v = (oi >= 0 && oi < 4);
      checks++; if (dut_out_valid !== exp_v) begin errors++; $display("FAIL b2b_valid[S=%0d]: got %b want %b at cycle %0d", stg, dut_out_valid, exp_v, c); end
      if (exp_v && dut_out_valid === 1'b1) begin
        checks++; if (dut_out_data !== eds[oi] || dut_out_tag !== tags[oi]) begin
          errors++; $display("FAIL b2b_result[S=%0d]: got %h/%h want %h/%h", stg, dut_out_data, dut_out_tag, eds[oi], tags[oi]);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int j;
    logic [W-1:0] held;
    logic [W-1:0] exp;
    exp_q.delete();
    out_ready = 1'b0;
    j = 0;
    held = '0;
    for (int c = 0; c < stg + 5; c++) begin
      in_valid = 1'b1; in_op = 4'(j); in_a = 32'h0100_0000 + 32'(j); in_b = 32'(j + 1); in_tag = 5'(20 + j);
      sample();
      checks++; if (dut_in_ready !== (j < stg)) begin errors++; $display("FAIL bp_in_ready[S=%0d]: got %b want %b at cycle %0d", stg, dut_in_ready, (j < stg), c); end
      if (c >= stg) begin
        checks++; if (dut_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[S=%0d]: got %b want 1 at cycle %0d", stg, dut_out_valid, c); end
        if (c == stg) begin
          held = dut_word;
          checks++; if (exp_q.size() == 0 || dut_word !== exp_q[0]) begin errors++; $display("FAIL bp_first[S=%0d]: got %h want %h", stg, dut_word, (exp_q.size() > 0) ? exp_q[0] : '0); end
        end else begin
          checks++; if (dut_word !== held) begin errors++; $display("FAIL bp_hold[S=%0d]: got %h want %h at cycle %0d", stg, dut_word, held, c); end
        end
      end
      if (in_valid && dut_in_ready) begin
        exp_q.push_back(model(in_op, in_a, in_b, in_tag));
        j++;
      end
      step();
    end
    // Release: one op drains and the blocked op enters on the same edge.
    out_ready = 1'b1;
    sample();
    checks++; if (dut_in_ready !== 1'b1 || dut_out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_simul[S=%0d]: got in_ready %b out_valid %b want 1 1", stg, dut_in_ready, dut_out_valid);
    end
    if (dut_out_valid === 1'b1) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++; if (dut_word !== exp) begin errors++; $display("FAIL bp_order[S=%0d]: got %h want %h", stg, dut_word, exp); end
    end
    if (dut_in_ready === 1'b1) exp_q.push_back(model(in_op, in_a, in_b, in_tag));
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 3 * stg + 6; c++) begin
      sample();
      if (dut_out_valid === 1'b1) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++; if (dut_word !== exp) begin errors++; $display("FAIL bp_order[S=%0d]: got %h want %h", stg, dut_word, exp); end
      end
      step();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain[S=%0d]: got %0d missing results want 0", stg, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'd100; in_b = 32'd1; in_tag = 5'd1;
    step();
    in_op = 4'd3; in_a = 32'd50; in_b = 32'd7; in_tag = 5'd2;
    step();
    flush = 1'b1; in_op = 4'd6; in_a = 32'hF0; in_b = 32'h0F; in_tag = 5'd3;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < stg + 3; c++) begin
      sample();
      checks++; if (dut_out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[S=%0d]: got valid %b tag %h want 0 at cycle %0d", stg, dut_out_valid, dut_out_tag, c); end
      step();
    end
    issue_one(4'd4, 32'h0000_F0F0, 32'h0000_FF00, 5'd9, 32'h0000_0FF0, 1'b0, "post_flush");
  endtask

  task automatic test_illegal();
    issue_one(4'd12, $urandom, $urandom, 5'd7, 32'h0, 1'b1, "illegal");
    issue_one(4'd1, 32'h1, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 1'b0, "sll_max");
  endtask

  task automatic test_random(input int n);
    logic         prev_hold;
    logic [W-1:0] prev_word;
    logic [W-1:0] exp;
    exp_q.delete();
    prev_hold = 1'b0;
    prev_word = '0;
    for (int c = 0; c < n; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15));
      in_a      = pick_operand();
      in_b      = pick_operand();
      in_tag    = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      sample();
      if (prev_hold) begin
        checks++; if (dut_out_valid !== 1'b1 || dut_word !== prev_word) begin
          errors++; $display("FAIL rand_hold[S=%0d]: got %b/%h want 1/%h at cycle %0d", stg, dut_out_valid, dut_word, prev_word, c);
        end
      end
      if (dut_out_valid === 1'b1 && out_ready) begin
        checks++; if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra[S=%0d]: got unexpected %h at cycle %0d", stg, dut_word, c);
        end else begin
          exp = exp_q.pop_front();
          if (dut_word !== exp) begin errors++; $display("FAIL rand_result[S=%0d]: got %h want %h at cycle %0d", stg, dut_word, exp, c); end
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && dut_in_ready === 1'b1) exp_q.push_back(model(in_op, in_a, in_b, in_tag));
      prev_hold = (dut_out_valid === 1'b1) && !out_ready && !flush;
      prev_word = dut_word;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < stg + 4; c++) begin
      sample();
      if (dut_out_valid === 1'b1) begin
        checks++; if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra[S=%0d]: got unexpected %h in drain", stg, dut_word);
        end else begin
          exp = exp_q.pop_front();
          if (dut_word !== exp) begin errors++; $display("FAIL rand_result[S=%0d]: got %h want %h in drain", stg, dut_word, exp); end
        end
      end
      step();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain[S=%0d]: got %0d missing results want 0", stg, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    logic seen;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'd5; in_b = 32'd6; in_tag = 5'd6;
    step();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < stg + 2 && !seen; c++) begin
      sample();
      if (dut_out_valid === 1'b1) seen = 1'b1;
      else step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL areset_setup[S=%0d]: got no out_valid want 1", stg); end
    // Between edges: assert reset and look before the next rising edge.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dut_out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid[S=%0d]: got %b want 0", stg, dut_out_valid); end
    checks++; if (dut_out_data !== 32'h0 || dut_out_tag !== 5'h0 || dut_out_illegal !== 1'b0) begin
      errors++; $display("FAIL areset_payload[S=%0d]: got %h/%h/%b want 0/0/0", stg, dut_out_data, dut_out_tag, dut_out_illegal);
    end
    checks++; if (dut_in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready[S=%0d]: got %b want 0", stg, dut_in_ready); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < stg + 3; c++) begin
      step();
      sample();
      checks++; if (dut_out_valid !== 1'b0) begin errors++; $display("FAIL areset_stale[S=%0d]: got valid %b want 0 at cycle %0d", stg, dut_out_valid, c); end
    end
    checks++; if (dut_in_ready !== 1'b1) begin errors++; $display("FAIL areset_recover[S=%0d]: got %b want 1", stg, dut_in_ready); end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int s = 0; s < 3; s++) begin
      sel = s;
      stg = (s == 0) ? 1 : (s == 1) ? 2 : 4;
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_illegal();
      test_random(300);
      test_async_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_fu_pipe.md
Name: alu_fu_pipe

Overview:
- Parametrised, pipelined integer ALU functional unit for the out-of-order backend.
- Accepts one issued op per cycle from the reservation station (valid/ready) and carries its ROB tag through STAGES register slots.
- Presents result + tag to the CDB arbiter (valid/ready) and supports full-pipeline flush on branch mispredict.
- Adds SLT/SLTU, an illegal-op flag, backpressure and flush, none of which the single-cycle combinational ALU has.

Parameters:
- XLEN, 32: operand/result width; power of two, 32 or 64.
- TAG_W, 5: ROB tag width.
- STAGES, 2: pipeline depth in register slots, legal 1..4; latency equals STAGES.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill all in-flight ops and the current input
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept this cycle
- in_op  in  4  operation code
- in_a  in  XLEN  operand A
- in_b  in  XLEN  operand B
- in_tag  in  TAG_W  ROB tag
- out_valid  out  1  result available
- out_ready  in  1  CDB accepts result
- out_data  out  XLEN  result
- out_tag  out  TAG_W  tag of result
- out_illegal  out  1  op code was unsupported

Behaviour:
- Reset: rst_n low asynchronously clears every slot valid bit and zeroes every slot's data, tag and illegal fields. While rst_n is low: out_valid=0, out_data=0, out_tag=0, out_illegal=0, in_ready=0. in_ready rises on the first clock edge after release.
- Op codes:
  - 0 add, 1 sll, 2 sra, 3 sub, 4 xor, 5 srl, 6 or, 7 and (low 3 bits match the existing aluop values).
  - 8 slt (signed less-than, result 1/0 zero-extended), 9 sltu (unsigned).
  - 10..15 are illegal: result 0, illegal=1.
- Arithmetic:
  - add/sub wrap modulo 2^XLEN.
  - Shift amount is in_b[$clog2(XLEN)-1:0]; upper bits of in_b are ignored.
  - sra replicates bit XLEN-1.
- Computation is combinational on the inputs and captured into slot 0. Slots 1..STAGES-1 only forward. The last slot drives the out_* ports directly from registers.
- Advance rule:
  - Last slot advances when out_valid && out_ready.
  - Slot k advances into slot k+1 when slot k+1 is empty or slot k+1 advances in the same cycle.
  - in_ready = !slot0.valid || slot0 advances, i.e. combinational from out_ready through the chain.
- Handshake:
  - Transfer in occurs on in_valid && in_ready. Transfer out occurs on out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data, out_tag and out_illegal hold stable.
  - in_valid may drop without a transfer.
- Latency and throughput: an op accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (STAGES cycles from issue to CDB), provided there is no backpressure. Throughput is 1 op/cycle at out_ready=1. With the pipeline full and out_ready=0, in_ready=0.
- Simultaneous accept and drain: when the pipeline is full and out_ready=1 in the same cycle as in_valid=1, both transfers happen and occupancy is unchanged.
- Flush:
  - flush=1 at an edge clears all slot valid bits. The input offered that cycle is discarded even if in_valid && in_ready.
  - An output handshake coinciding with flush still counts as taken by the consumer; the CDB is responsible for ignoring it.
  - in_ready may be 1 during the flush cycle. The pipeline is empty the cycle after.
- Reset mid-operation: all in-flight ops are lost and nothing is replayed.
- Data fields of invalid slots are don't-care internally. When a slot is invalid, the out_* data ports must still show the last value held, never X.

Test Plan:
- Reset, XLEN=32, STAGES=2, out_ready=1: issue add a=0xFFFFFFFF b=0x1 tag=3 → out_valid 2 cycles later, out_data=0x00000000, out_tag=3, out_illegal=0.
- Back-to-back ops:
  - Stimulus: sra a=0x80000000 b=0x24; sltu a=1 b=0xFFFFFFFF; slt a=1 b=0xFFFFFFFF; sub a=0 b=1.
  - Response: consecutive cycles give 0xF8000000 (shift 4), 1, 0, 0xFFFFFFFF, in order with tags preserved, in_ready held at 1.
- Backpressure:
  - Stimulus: out_ready=0 while issuing 3 ops.
  - Response: the first two are accepted, in_ready=0 on the third, out_data stable for 5 cycles.
  - Then out_ready=1: the third is accepted in the same cycle the first drains, and all three emerge in order.
- Flush: 2 ops in flight plus in_valid=1 with flush=1 → next cycle out_valid=0; none of the three ever appear; a subsequent op has normal 2-cycle latency.
- Illegal/edge: in_op=12 tag=7 → out_illegal=1, out_data=0. sll a=1 b=0xFFFFFFFF → 0x80000000. Repeat the suite with STAGES=1 and 4, checking latency 1/4.
- Async reset asserted mid-stream with out_valid=1 → outputs zero immediately, before the next clock edge; no stale op after release.
